// File: rtl/shift_register_seq_if.sv
// Handshake/data bundle for shift_register_seq.
//   master : requester side (drives start/op/amt/d/il/ir, observes q/co/busy/done)
//   slave  : shift register side
interface shift_register_seq_if #(
    parameter int N  = 8,
    parameter int AW = 3
);
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [N-1:0]  d;
    logic          il;
    logic          ir;
    logic [N-1:0]  q;
    logic          co;
    logic          busy;
    logic          done;

    modport master (
        output start, op, amt, d, il, ir,
        input  q, co, busy, done
    );

    modport slave (
        input  start, op, amt, d, il, ir,
        output q, co, busy, done
    );
endinterface

// File: rtl/shift_register_seq.sv
// Sequential universal shift register. Multi-position shifts/rotates advance
// one bit per clock under a start/busy/done handshake.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   bus    - slave modport of shift_register_seq_if:
//            start/op/amt/d  request, op code, shift count, load data
//            il/ir           live serial fill bits for left/right shifts
//            q/co            register contents, last bit shifted out
//            busy/done       multi-cycle in progress, one-cycle completion
//
// State table:
//   state   | meaning
//   S_IDLE  | waiting for start; single-edge ops and first shift step here
//   S_SHIFT | remaining steps of a multi-position shift, one per edge
module shift_register_seq #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_register_seq_if.slave   bus
);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_ROL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_ASR  = 3'b101,
        OP_CLR  = 3'b110,
        OP_NOP  = 3'b111
    } op_t;

    localparam logic [AW:0] K_MAX = (AW+1)'(N);

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_op, w_op_nxt;
    logic [AW-1:0] r_cnt, w_cnt_nxt;
    logic [N-1:0]  r_q, w_q_nxt;
    logic          r_co, w_co_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;

    logic [AW:0]   w_amt_ext;
    logic [AW:0]   w_k;
    logic [2:0]    w_step_op;
    logic [N-1:0]  w_step_q;
    logic          w_step_co;
    logic          w_is_shift;

    // Saturate the requested amount to N
    assign w_amt_ext = {1'b0, bus.amt};
    assign w_k       = (w_amt_ext > K_MAX) ? K_MAX : w_amt_ext;

    // In IDLE the first step uses the incoming op; afterwards the latched one
    assign w_step_op  = (r_state == S_IDLE) ? bus.op : r_op;
    assign w_is_shift = (bus.op == OP_SHL) || (bus.op == OP_SHR) || (bus.op == OP_ROL) ||
                        (bus.op == OP_ROR) || (bus.op == OP_ASR);

    // One-bit step of the shift datapath
    always_comb begin
        w_step_q  = r_q;
        w_step_co = r_co;
        case (w_step_op)
            OP_SHL: begin
                w_step_q  = {r_q[N-2:0], bus.il};
                w_step_co = r_q[N-1];
            end
            OP_SHR: begin
                w_step_q  = {bus.ir, r_q[N-1:1]};
                w_step_co = r_q[0];
            end
            OP_ROL: begin
                w_step_q  = {r_q[N-2:0], r_q[N-1]};
                w_step_co = r_q[N-1];
            end
            OP_ROR: begin
                w_step_q  = {r_q[0], r_q[N-1:1]};
                w_step_co = r_q[0];
            end
            OP_ASR: begin
                w_step_q  = {r_q[N-1], r_q[N-1:1]};
                w_step_co = r_q[0];
            end
            default: begin
                w_step_q  = r_q;
                w_step_co = r_co;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_co_nxt    = r_co;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_op_nxt = bus.op;
                    if (w_is_shift) begin
                        if (w_k == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_q_nxt   = w_step_q;
                            w_co_nxt  = w_step_co;
                            w_cnt_nxt = AW'(w_k - 1'b1);
                            if (w_k == (AW+1)'(1)) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_busy_nxt  = 1'b1;
                                w_state_nxt = S_SHIFT;
                            end
                        end
                    end else begin
                        if (bus.op == OP_LOAD) begin
                            w_q_nxt = bus.d;
                        end else if (bus.op == OP_CLR) begin
                            w_q_nxt  = '0;
                            w_co_nxt = 1'b0;
                        end
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                w_q_nxt   = w_step_q;
                w_co_nxt  = w_step_co;
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == AW'(1)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_co    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_co    <= w_co_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.q    = r_q;
    assign bus.co   = r_co;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_shift_register_seq.sv
// Directed bench for shift_register_seq (N=8, AW=4 so amounts of 8 and
// above can be requested).
module tb_shift_register_seq;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ASR  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    shift_register_seq_if #(.N(8), .AW(4)) bus ();

    shift_register_seq #(.N(8), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and wait (bounded) until done is seen; n = edges taken
    task automatic run_op(input logic [2:0] o, input logic [3:0] a, input logic [7:0] dv,
                          output int n);
        bus.start = 1'b1;
        bus.op    = o;
        bus.amt   = a;
        bus.d     = dv;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    logic [7:0] ir_seq;
    int         n;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_NOP_VAL();
        bus.amt   = '0;
        bus.d     = '0;
        bus.il    = 1'b0;
        bus.ir    = 1'b0;
        #12;
        check("rst_q",    32'(bus.q),    32'h00);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_co",   32'(bus.co),   32'd0);
        #4 reset = 1'b0;
        tick();

        // LOAD
        bus.start = 1'b1; bus.op = OP_LOAD; bus.d = 8'h96;
        tick();
        bus.start = 1'b0;
        check("load_q",    32'(bus.q),    32'h96);
        check("load_done", 32'(bus.done), 32'd1);
        check("load_busy", 32'(bus.busy), 32'd0);
        tick();
        check("load_done_off", 32'(bus.done), 32'd0);
        check("load_busy_off", 32'(bus.busy), 32'd0);

        // SHL 3 on 0x81 with il=1
        run_op(OP_LOAD, 4'd0, 8'h81, n);
        tick();
        bus.il = 1'b1;
        bus.start = 1'b1; bus.op = OP_SHL; bus.amt = 4'd3;
        tick();
        bus.start = 1'b0;
        check("shl_q1",    32'(bus.q),    32'h03);
        check("shl_busy1", 32'(bus.busy), 32'd1);
        check("shl_done1", 32'(bus.done), 32'd0);
        tick();
        check("shl_q2",    32'(bus.q),    32'h07);
        check("shl_busy2", 32'(bus.busy), 32'd1);
        check("shl_done2", 32'(bus.done), 32'd0);
        tick();
        check("shl_q3",    32'(bus.q),    32'h0F);
        check("shl_busy3", 32'(bus.busy), 32'd0);
        check("shl_done3", 32'(bus.done), 32'd1);
        check("shl_co",    32'(bus.co),   32'd0);
        tick();
        check("shl_done_off", 32'(bus.done), 32'd0);
        bus.il = 1'b0;

        // ASR 7 on 0x80
        run_op(OP_LOAD, 4'd0, 8'h80, n);
        run_op(OP_ASR, 4'd7, 8'h00, n);
        check("asr_cycles", 32'(n),      32'd7);
        check("asr_q",      32'(bus.q),  32'hFF);
        check("asr_co",     32'(bus.co), 32'd0);

        // ROR 8 on 0x5A
        run_op(OP_LOAD, 4'd0, 8'h5A, n);
        run_op(OP_ROR, 4'd8, 8'h00, n);
        check("ror_cycles", 32'(n),      32'd8);
        check("ror_q",      32'(bus.q),  32'h5A);
        check("ror_co",     32'(bus.co), 32'd0);

        // ROL 4 on 0x96 with start held through busy; op swapped to CLR meanwhile
        run_op(OP_LOAD, 4'd0, 8'h96, n);
        tick();
        bus.start = 1'b1; bus.op = OP_ROL; bus.amt = 4'd4;
        tick();
        bus.op = OP_CLR; bus.amt = 4'd1;
        check("rol_q1",    32'(bus.q),    32'h2D);
        check("rol_busy1", 32'(bus.busy), 32'd1);
        tick();
        check("rol_q2",    32'(bus.q),    32'h5A);
        check("rol_done2", 32'(bus.done), 32'd0);
        tick();
        check("rol_q3",    32'(bus.q),    32'hB4);
        check("rol_done3", 32'(bus.done), 32'd0);
        tick();
        bus.start = 1'b0;
        check("rol_q4",    32'(bus.q),    32'h69);
        check("rol_co",    32'(bus.co),   32'd1);
        check("rol_done4", 32'(bus.done), 32'd1);
        check("rol_busy4", 32'(bus.busy), 32'd0);
        tick();
        check("rol_done_once", 32'(bus.done), 32'd0);
        check("rol_q_hold",    32'(bus.q),    32'h69);

        // Back-to-back: SHR 1 then LOAD accepted in the done cycle
        bus.ir = 1'b0;
        bus.start = 1'b1; bus.op = OP_SHR; bus.amt = 4'd1;
        tick();
        check("b2b_q1",    32'(bus.q),    32'h34);
        check("b2b_co1",   32'(bus.co),   32'd1);
        check("b2b_done1", 32'(bus.done), 32'd1);
        check("b2b_busy1", 32'(bus.busy), 32'd0);
        bus.op = OP_LOAD; bus.d = 8'hC3;
        tick();
        bus.start = 1'b0;
        check("b2b_q2",    32'(bus.q),    32'hC3);
        check("b2b_done2", 32'(bus.done), 32'd1);
        tick();
        check("b2b_done_off", 32'(bus.done), 32'd0);

        // SHR amt=0
        bus.start = 1'b1; bus.op = OP_SHR; bus.amt = 4'd0;
        tick();
        bus.start = 1'b0;
        check("shr0_q",    32'(bus.q),    32'hC3);
        check("shr0_co",   32'(bus.co),   32'd1);
        check("shr0_done", 32'(bus.done), 32'd1);
        check("shr0_busy", 32'(bus.busy), 32'd0);
        tick();

        // Serial stream into an empty register; op/amt/d scrambled mid-shift
        run_op(OP_CLR, 4'd0, 8'h00, n);
        check("clr_q",  32'(bus.q),  32'h00);
        check("clr_co", 32'(bus.co), 32'd0);
        tick();
        ir_seq = 8'b0100_1101;   // bit i = ir on step i
        bus.start = 1'b1; bus.op = OP_SHR; bus.amt = 4'd8; bus.ir = ir_seq[0];
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            bus.ir  = ir_seq[i];
            bus.op  = OP_LOAD;
            bus.d   = 8'hEE;
            bus.amt = 4'd2;
            tick();
        end
        check("stream_q",    32'(bus.q),    32'h4D);
        check("stream_co",   32'(bus.co),   32'd0);
        check("stream_done", 32'(bus.done), 32'd1);
        tick();

        // Saturated amount: ROL 15 acts as ROL 8
        run_op(OP_ROL, 4'd15, 8'h00, n);
        check("sat_cycles", 32'(n),      32'd8);
        check("sat_q",      32'(bus.q),  32'h4D);
        check("sat_co",     32'(bus.co), 32'd1);
        tick();

        // Reset mid-shift
        run_op(OP_LOAD, 4'd0, 8'hA5, n);
        tick();
        bus.start = 1'b1; bus.op = OP_SHL; bus.amt = 4'd5;
        tick();
        bus.start = 1'b0;
        tick();
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_q",    32'(bus.q),    32'h00);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_co",   32'(bus.co),   32'd0);
        #2 reset = 1'b0;
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_done", 32'(bus.done), 32'd0);
        run_op(OP_LOAD, 4'd0, 8'h3C, n);
        check("post_rst_cycles", 32'(n),     32'd1);
        check("post_rst_q",      32'(bus.q), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    function automatic logic [2:0] OP_NOP_VAL();
        return 3'b111;
    endfunction

endmodule
